// File: rtl/stream_demux3_pkg.sv
// Shared types and defaults for the 1-to-3 stream distributor.
package stream_demux_pkg;

  typedef enum logic [1:0] {
    DEST_ALPHA = 2'd0,
    DEST_BETA  = 2'd1,
    DEST_GAMMA = 2'd2,
    DEST_DROP  = 2'd3
  } dest_e;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_CNT_WIDTH = 8;

endpackage

// File: rtl/stream_demux3_if.sv
// Producer-side and consumer-side signals of stream_demux3; slave is the block's view.
interface stream_demux3_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
);
  logic                 cs;
  logic [1:0]           sel;
  logic [WIDTH-1:0]     in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     alpha_data;
  logic                 alpha_valid;
  logic                 alpha_ready;
  logic [WIDTH-1:0]     beta_data;
  logic                 beta_valid;
  logic                 beta_ready;
  logic [WIDTH-1:0]     gamma_data;
  logic                 gamma_valid;
  logic                 gamma_ready;
  logic                 clear_drops;
  logic [CNT_WIDTH-1:0] drop_count;

  modport slave (
    input  cs, sel, in_data, in_valid, alpha_ready, beta_ready, gamma_ready, clear_drops,
    output in_ready, alpha_data, alpha_valid, beta_data, beta_valid, gamma_data, gamma_valid,
           drop_count
  );

  modport master (
    output cs, sel, in_data, in_valid, alpha_ready, beta_ready, gamma_ready, clear_drops,
    input  in_ready, alpha_data, alpha_valid, beta_data, beta_valid, gamma_data, gamma_valid,
           drop_count
  );
endinterface

// File: rtl/stream_demux3_slot.sv
// One-entry valid/ready holding register; 1-cycle fill latency, refillable in the cycle it drains.
module stream_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             fill,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data_out,
  output logic             can_fill
);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      valid    <= 1'b0;
      data_out <= '0;
    end else if (fill) begin
      valid    <= 1'b1;
      data_out <= data_in;
    end else if (valid && ready) begin
      // data_out deliberately left untouched when the entry empties
      valid <= 1'b0;
    end
  end

  assign can_fill = !valid || ready;

endmodule

// File: rtl/stream_demux3.sv
// Steers one byte stream into three registered outputs (1-cycle latency) or a saturating drop counter;
// in_ready follows only the targeted slot, so a stalled consumer never blocks the other two.
module stream_demux3
  import stream_demux_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input logic             clk,
  input logic             nReset,
  stream_demux3_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  dest_e            dst;
  logic             in_ready_int;
  logic             accept;
  logic [3:0]       can_fill;
  logic [2:0]       fill;
  logic [2:0]       slot_rdy;
  logic [2:0]       slot_vld;
  logic [WIDTH-1:0] slot_dat [3];
  logic [CNT_WIDTH-1:0] drop_cnt;

  assign dst      = dest_e'(bus.sel);
  assign slot_rdy = {bus.gamma_ready, bus.beta_ready, bus.alpha_ready};

  // Drop destination is always willing, so the fourth entry is tied high.
  assign can_fill[3] = 1'b1;

  assign in_ready_int = nReset && bus.cs && can_fill[bus.sel];
  assign accept       = bus.in_valid && in_ready_int;

  always_comb begin
    fill = '0;
    if (accept) begin
      unique case (dst)
        DEST_ALPHA: fill[0] = 1'b1;
        DEST_BETA:  fill[1] = 1'b1;
        DEST_GAMMA: fill[2] = 1'b1;
        DEST_DROP:  fill    = '0;
      endcase
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_slot
    stream_slot #(.WIDTH(WIDTH)) u_slot (
      .clk      (clk),
      .nReset   (nReset),
      .fill     (fill[k]),
      .data_in  (bus.in_data),
      .ready    (slot_rdy[k]),
      .valid    (slot_vld[k]),
      .data_out (slot_dat[k]),
      .can_fill (can_fill[k])
    );
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      drop_cnt <= '0;
    end else if (bus.clear_drops) begin
      drop_cnt <= '0;
    end else if (accept && dst == DEST_DROP && drop_cnt != CNT_MAX) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign bus.in_ready    = in_ready_int;
  assign bus.alpha_data  = slot_dat[0];
  assign bus.alpha_valid = slot_vld[0];
  assign bus.beta_data   = slot_dat[1];
  assign bus.beta_valid  = slot_vld[1];
  assign bus.gamma_data  = slot_dat[2];
  assign bus.gamma_valid = slot_vld[2];
  assign bus.drop_count  = drop_cnt;

endmodule

// File: tb/tb_stream_demux3.sv
// Scoreboard bench for stream_demux3: stimulus queues expected bytes, a negedge monitor checks handshakes.
module tb_stream_demux3;

  logic clk = 1'b0;
  logic nReset;
  always #5 clk = ~clk;

  stream_demux3_if #(.WIDTH(8), .CNT_WIDTH(8)) bus ();

  stream_demux3 #(.WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int exp_drop    = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] q_g[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic mon(input int ch, input logic [7:0] d);
    logic [7:0] e;
    logic       have;
    string      nm;
    have = 1'b0;
    e    = 8'h00;
    case (ch)
      0: begin nm = "alpha"; if (q_a.size() > 0) begin have = 1'b1; e = q_a.pop_front(); end end
      1: begin nm = "beta";  if (q_b.size() > 0) begin have = 1'b1; e = q_b.pop_front(); end end
      default: begin nm = "gamma"; if (q_g.size() > 0) begin have = 1'b1; e = q_g.pop_front(); end end
    endcase
    vectors++;
    if (!have) begin
      miscompares++;
      $display("FAIL %s_unexpected: got %02h, expected no byte", nm, d);
    end else if (d !== e) begin
      miscompares++;
      $display("FAIL %s_data: got %02h, expected %02h", nm, d, e);
    end
  endtask

  // Handshakes are stable at the falling edge and complete on the next rising edge.
  always @(negedge clk) begin
    if (nReset === 1'b1) begin
      if (bus.alpha_valid && bus.alpha_ready) mon(0, bus.alpha_data);
      if (bus.beta_valid  && bus.beta_ready)  mon(1, bus.beta_data);
      if (bus.gamma_valid && bus.gamma_ready) mon(2, bus.gamma_data);
    end
  end

  task automatic send(input logic [7:0] d, input logic [1:0] s, output int waits);
    logic done;
    bus.in_data  = d;
    bus.sel      = s;
    bus.in_valid = 1'b1;
    waits = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      waits++;
      if (bus.in_ready === 1'b1) begin
        done = 1'b1;
        case (s)
          2'd0: q_a.push_back(d);
          2'd1: q_b.push_back(d);
          2'd2: q_g.push_back(d);
          default: begin
            if (bus.clear_drops) exp_drop = 0;
            else if (exp_drop < 255) exp_drop++;
          end
        endcase
      end else if (waits >= 50) begin
        done = 1'b1;
        vectors++;
        miscompares++;
        $display("FAIL send_timeout: got no in_ready, expected accept of %02h", d);
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wt;
    nReset          = 1'b0;
    bus.cs          = 1'b1;
    bus.sel         = 2'd0;
    bus.in_data     = 8'h5C;
    bus.in_valid    = 1'b1;
    bus.alpha_ready = 1'b0;
    bus.beta_ready  = 1'b0;
    bus.gamma_ready = 1'b0;
    bus.clear_drops = 1'b0;

    // reset held with a pending byte
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_valids", {bus.alpha_valid, bus.beta_valid, bus.gamma_valid}, 0);
    check("rst_data", {bus.alpha_data, bus.beta_data, bus.gamma_data}, 0);
    check("rst_drop", bus.drop_count, 0);
    tick();
    nReset       = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_valids", {bus.alpha_valid, bus.beta_valid, bus.gamma_valid}, 0);
    tick();

    // routing with all consumers stalled
    send(8'h11, 2'd0, wt);
    check("alpha_lat", {bus.alpha_valid, bus.alpha_data}, {1'b1, 8'h11});
    send(8'h22, 2'd1, wt);
    check("beta_lat", {bus.beta_valid, bus.beta_data}, {1'b1, 8'h22});
    send(8'h33, 2'd2, wt);
    check("gamma_lat", {bus.gamma_valid, bus.gamma_data}, {1'b1, 8'h33});
    check("route_wait", wt, 1);
    bus.in_data  = 8'h44;
    bus.sel      = 2'd0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("alpha_full_in_ready", bus.in_ready, 0);
    tick();
    bus.alpha_ready = 1'b1;
    send(8'h44, 2'd0, wt);
    check("refill_wait", wt, 1);
    check("refill_data", {bus.alpha_valid, bus.alpha_data}, {1'b1, 8'h44});

    // back-to-back stream on alpha
    for (int i = 0; i < 16; i++) begin
      send(8'(i), 2'd0, wt);
      check("b2b_wait", wt, 1);
    end
    repeat (2) tick();
    bus.alpha_ready = 1'b0;
    check("b2b_drained", q_a.size(), 0);

    // beta held at A5 while gamma keeps flowing
    bus.beta_ready = 1'b1;
    send(8'hA5, 2'd1, wt);
    bus.beta_ready  = 1'b0;
    bus.gamma_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(8'h50 + 8'(i), 2'd2, wt);
      check("gamma_flow_wait", wt, 1);
      check("beta_hold", {bus.beta_valid, bus.beta_data}, {1'b1, 8'hA5});
    end
    bus.in_data  = 8'hFF;
    bus.sel      = 2'd1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("beta_full_in_ready", bus.in_ready, 0);
    tick();
    bus.in_valid   = 1'b0;
    bus.beta_ready = 1'b1;
    repeat (2) tick();
    bus.beta_ready  = 1'b0;
    bus.gamma_ready = 1'b0;
    check("bp_drained", q_b.size() + q_g.size(), 0);

    // chip select off while alpha drains
    send(8'h99, 2'd0, wt);
    bus.cs          = 1'b0;
    bus.in_data     = 8'h77;
    bus.in_valid    = 1'b1;
    bus.alpha_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.sel = 2'(i);
      @(negedge clk);
      check("cs0_in_ready", bus.in_ready, 0);
      tick();
    end
    bus.in_valid    = 1'b0;
    bus.alpha_ready = 1'b0;
    check("cs0_valids", {bus.alpha_valid, bus.beta_valid, bus.gamma_valid}, 0);
    check("cs0_drop", bus.drop_count, 0);
    bus.cs = 1'b1;

    // drop counter saturation and clear priority
    for (int i = 0; i < 300; i++) begin
      send(8'(i), 2'd3, wt);
      if (i == 99)  check("drop_100", bus.drop_count, exp_drop);
      if (i == 254) check("drop_255", bus.drop_count, 255);
    end
    check("drop_sat", bus.drop_count, 255);
    bus.clear_drops = 1'b1;
    send(8'hEE, 2'd3, wt);
    bus.clear_drops = 1'b0;
    check("clear_vs_drop", bus.drop_count, 0);
    send(8'hEF, 2'd3, wt);
    check("drop_after_clear", bus.drop_count, 1);

    // asynchronous reset between edges with full slots
    send(8'hC1, 2'd0, wt);
    send(8'hC3, 2'd2, wt);
    #2;
    nReset = 1'b0;
    #1;
    check("arst_valids", {bus.alpha_valid, bus.beta_valid, bus.gamma_valid}, 0);
    check("arst_data", {bus.alpha_data, bus.gamma_data}, 0);
    check("arst_drop", bus.drop_count, 0);
    q_a.delete();
    q_g.delete();
    exp_drop = 0;
    tick();
    nReset          = 1'b1;
    bus.alpha_ready = 1'b1;
    bus.gamma_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("arst_no_replay", {bus.alpha_valid, bus.gamma_valid}, 0);
    end
    tick();
    send(8'hD1, 2'd0, wt);
    repeat (3) tick();
    check("final_queues", q_a.size() + q_b.size() + q_g.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
